// File: rtl/mem_access_xbar_n_pkg.sv
// Shared types and helpers for the N-initiator memory access crossbar.
// Holds FSM state encodings, response status codes and the burst length decoder.
package mai_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_REQ  = 2'b01,
    W_DATA = 2'b10
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_HOLD = 1'b1
  } rd_state_e;

  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_EXOKAY = 2'b01;
  localparam logic [1:0] ST_SLVERR = 2'b10;
  localparam logic [1:0] ST_DECERR = 2'b11;

  // Burst length code to beat count: 2^len.
  function automatic logic [8:0] len2beats(input logic [2:0] len);
    return 9'd1 << len;
  endfunction

endpackage

// File: rtl/mem_access_xbar_n_qos_rr_arbiter.sv
// QoS-priority arbiter with round-robin tie-break among equal-QoS requesters.
// The pointer moves to winner+1 whenever an advance strobe coincides with a valid request.
module qos_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int QOS_W = 4,
  parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_M-1:0]       i_valid,
  input  logic [NUM_M*QOS_W-1:0] i_qos,
  input  logic                   i_advance,
  output logic [NUM_M-1:0]       o_gnt,
  output logic [IDX_W-1:0]       o_gnt_idx,
  output logic                   o_any_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_best;
  logic [IDX_W-1:0] w_next;
  logic [QOS_W-1:0] w_best_qos;
  logic             w_found;
  int               w_best_dist;

  // Distance of index m from the pointer, walking upward with wrap.
  function automatic int rr_dist(input int m, input int ptr);
    return (m + NUM_M - ptr) % NUM_M;
  endfunction

  // Highest QoS wins; equal QoS resolved by the smallest distance from the pointer.
  always_comb begin
    w_found     = 1'b0;
    w_best      = '0;
    w_best_qos  = '0;
    w_best_dist = 0;
    for (int m = 0; m < NUM_M; m++) begin
      if (i_valid[m] &&
          (!w_found ||
           (i_qos[m*QOS_W +: QOS_W] > w_best_qos) ||
           ((i_qos[m*QOS_W +: QOS_W] == w_best_qos) &&
            (rr_dist(m, int'(r_ptr)) < w_best_dist)))) begin
        w_found     = 1'b1;
        w_best      = IDX_W'(m);
        w_best_qos  = i_qos[m*QOS_W +: QOS_W];
        w_best_dist = rr_dist(m, int'(r_ptr));
      end else begin
        w_found = w_found;
      end
    end
    for (int m = 0; m < NUM_M; m++) begin
      o_gnt[m] = w_found && (w_best == IDX_W'(m));
    end
    w_next      = (int'(w_best) == NUM_M - 1) ? '0 : w_best + IDX_W'(1);
    o_gnt_idx   = w_best;
    o_any_valid = w_found;
  end

  // Round-robin pointer update on each grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= w_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/mem_access_xbar_n.sv
// N-initiator memory access crossbar onto a single MAC port.
// Independent write and read request paths; read responses are routed back by ID.
module mem_access_xbar_n
  import mai_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int QOS_W  = 4,
  parameter int LEN_W  = 2,
  parameter int ID_W   = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_M-1:0]              iValidWr,
  input  logic [NUM_M*ADDR_W-1:0]       iAddrWr,
  input  logic [NUM_M*TAG_W-1:0]        iTagWr,
  input  logic [NUM_M*LEN_W-1:0]        iLenWr,
  input  logic [NUM_M*QOS_W-1:0]        iQoSWr,
  output logic [NUM_M-1:0]              oReadyWr,
  input  logic [NUM_M-1:0]              iDataValidWr,
  input  logic [NUM_M*DATA_W-1:0]       iDataWr,
  input  logic [NUM_M*(DATA_W/8)-1:0]   iMaskWr,
  input  logic [NUM_M-1:0]              iEoD,
  output logic [NUM_M-1:0]              oDataReadyWr,
  input  logic [NUM_M-1:0]              iValidRd,
  input  logic [NUM_M*ADDR_W-1:0]       iAddrRd,
  input  logic [NUM_M*TAG_W-1:0]        iTagRd,
  input  logic [NUM_M*LEN_W-1:0]        iLenRd,
  input  logic [NUM_M*QOS_W-1:0]        iQoSRd,
  output logic [NUM_M-1:0]              oReadyRd,
  output logic [NUM_M-1:0]              oValidRsp,
  output logic [TAG_W-1:0]              oTagRsp,
  output logic [DATA_W-1:0]             oDataRsp,
  output logic [1:0]                    oStatusRsp,
  output logic                          oEoDRsp,
  input  logic [NUM_M-1:0]              iReadyRsp,
  output logic                          oMAC_ValidWr,
  output logic [ADDR_W-1:0]             oMAC_AddrWr,
  output logic [TAG_W-1:0]              oMAC_TagWr,
  output logic [ID_W-1:0]               oMAC_IdWr,
  output logic [LEN_W-1:0]              oMAC_LenWr,
  output logic [QOS_W-1:0]              oMAC_QoSWr,
  input  logic                          iMAC_ReadyWr,
  output logic                          oMAC_DataValid,
  output logic [DATA_W-1:0]             oMAC_DataWr,
  output logic [DATA_W/8-1:0]           oMAC_MaskWr,
  output logic                          oMAC_EoD,
  input  logic                          iMAC_DataReady,
  output logic                          oMAC_ValidRd,
  output logic [ADDR_W-1:0]             oMAC_AddrRd,
  output logic [TAG_W-1:0]              oMAC_TagRd,
  output logic [ID_W-1:0]               oMAC_IdRd,
  output logic [LEN_W-1:0]              oMAC_LenRd,
  output logic [QOS_W-1:0]              oMAC_QoSRd,
  input  logic                          iMAC_ReadyRd,
  input  logic                          iMAC_ValidRsp,
  input  logic [ID_W-1:0]               iMAC_IdRsp,
  input  logic [TAG_W-1:0]              iMAC_TagRsp,
  input  logic [DATA_W-1:0]             iMAC_DataRsp,
  input  logic [1:0]                    iMAC_StatusRsp,
  input  logic                          iMAC_EoD,
  output logic                          oMAC_ReadyRsp,
  output logic [1:0]                    oErr
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [ID_W:0] NUM_M_V = (ID_W+1)'(NUM_M);

  wr_state_e          r_wstate;
  rd_state_e          r_rstate;
  logic [NUM_M-1:0]   r_ready_wr, r_ready_rd;
  logic               r_valid_wr, r_valid_rd;
  logic [ADDR_W-1:0]  r_addr_wr, r_addr_rd;
  logic [TAG_W-1:0]   r_tag_wr, r_tag_rd;
  logic [ID_W-1:0]    r_id_wr, r_id_rd;
  logic [LEN_W-1:0]   r_len_wr, r_len_rd;
  logic [QOS_W-1:0]   r_qos_wr, r_qos_rd;
  logic [8:0]         r_beats;
  logic               r_err_eod, r_err_id;

  logic [NUM_M-1:0]   w_wgnt, w_rgnt, w_sel;
  logic [IDX_W-1:0]   w_wgidx, w_rgidx;
  logic               w_wany, w_rany;
  logic [ADDR_W-1:0]  w_waddr, w_raddr;
  logic [TAG_W-1:0]   w_wtag, w_rtag;
  logic [LEN_W-1:0]   w_wlen, w_rlen;
  logic [QOS_W-1:0]   w_wqos, w_rqos;
  logic               w_in_data, w_last, w_dv, w_eod_in, w_beat;
  logic [DATA_W-1:0]  w_data;
  logic [MASK_W-1:0]  w_mask;
  logic               w_id_ok, w_rsp_rdy;

  qos_rr_arbiter #(.NUM_M(NUM_M), .QOS_W(QOS_W), .IDX_W(IDX_W)) u_arb_wr (
    .clk(clk), .resetn(resetn), .i_valid(iValidWr), .i_qos(iQoSWr),
    .i_advance(r_wstate == W_IDLE),
    .o_gnt(w_wgnt), .o_gnt_idx(w_wgidx), .o_any_valid(w_wany)
  );

  qos_rr_arbiter #(.NUM_M(NUM_M), .QOS_W(QOS_W), .IDX_W(IDX_W)) u_arb_rd (
    .clk(clk), .resetn(resetn), .i_valid(iValidRd), .i_qos(iQoSRd),
    .i_advance(r_rstate == R_IDLE),
    .o_gnt(w_rgnt), .o_gnt_idx(w_rgidx), .o_any_valid(w_rany)
  );

  // AND-OR muxes: winner request fields and locked-initiator write data.
  always_comb begin
    w_waddr = '0; w_wtag = '0; w_wlen = '0; w_wqos = '0;
    w_raddr = '0; w_rtag = '0; w_rlen = '0; w_rqos = '0;
    w_dv = 1'b0; w_eod_in = 1'b0; w_data = '0; w_mask = '0;
    for (int m = 0; m < NUM_M; m++) begin
      w_sel[m] = (r_id_wr == ID_W'(m));
      w_waddr  = w_waddr | ({ADDR_W{w_wgnt[m]}} & iAddrWr[m*ADDR_W +: ADDR_W]);
      w_wtag   = w_wtag  | ({TAG_W{w_wgnt[m]}}  & iTagWr[m*TAG_W +: TAG_W]);
      w_wlen   = w_wlen  | ({LEN_W{w_wgnt[m]}}  & iLenWr[m*LEN_W +: LEN_W]);
      w_wqos   = w_wqos  | ({QOS_W{w_wgnt[m]}}  & iQoSWr[m*QOS_W +: QOS_W]);
      w_raddr  = w_raddr | ({ADDR_W{w_rgnt[m]}} & iAddrRd[m*ADDR_W +: ADDR_W]);
      w_rtag   = w_rtag  | ({TAG_W{w_rgnt[m]}}  & iTagRd[m*TAG_W +: TAG_W]);
      w_rlen   = w_rlen  | ({LEN_W{w_rgnt[m]}}  & iLenRd[m*LEN_W +: LEN_W]);
      w_rqos   = w_rqos  | ({QOS_W{w_rgnt[m]}}  & iQoSRd[m*QOS_W +: QOS_W]);
      w_dv     = w_dv     | (w_sel[m] & iDataValidWr[m]);
      w_eod_in = w_eod_in | (w_sel[m] & iEoD[m]);
      w_data   = w_data | ({DATA_W{w_sel[m]}} & iDataWr[m*DATA_W +: DATA_W]);
      w_mask   = w_mask | ({MASK_W{w_sel[m]}} & iMaskWr[m*MASK_W +: MASK_W]);
    end
    w_in_data = (r_wstate == W_DATA);
    w_last    = (r_beats == 9'd1);
    w_beat    = w_in_data && w_dv && iMAC_DataReady;
  end

  // Write path FSM: arbitrate, hold request, then count burst beats.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate   <= W_IDLE;
      r_ready_wr <= '0;
      r_valid_wr <= 1'b0;
      r_addr_wr  <= '0;
      r_tag_wr   <= '0;
      r_id_wr    <= '0;
      r_len_wr   <= '0;
      r_qos_wr   <= '0;
      r_beats    <= '0;
      r_err_eod  <= 1'b0;
    end else begin
      r_ready_wr <= '0;
      case (r_wstate)
        W_IDLE: begin
          if (w_wany) begin
            r_valid_wr <= 1'b1;
            r_addr_wr  <= w_waddr;
            r_tag_wr   <= w_wtag;
            r_id_wr    <= ID_W'(w_wgidx);
            r_len_wr   <= w_wlen;
            r_qos_wr   <= w_wqos;
            r_ready_wr <= w_wgnt;
            r_wstate   <= W_REQ;
          end
        end
        W_REQ: begin
          if (iMAC_ReadyWr) begin
            r_valid_wr <= 1'b0;
            r_beats    <= len2beats(3'(r_len_wr));
            r_wstate   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_eod_in != w_last) begin
              r_err_eod <= 1'b1;
            end
            r_beats <= r_beats - 9'd1;
            if (w_last) begin
              r_wstate <= W_IDLE;
            end
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read path FSM: arbitrate, then hold the request until the MAC takes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate   <= R_IDLE;
      r_ready_rd <= '0;
      r_valid_rd <= 1'b0;
      r_addr_rd  <= '0;
      r_tag_rd   <= '0;
      r_id_rd    <= '0;
      r_len_rd   <= '0;
      r_qos_rd   <= '0;
    end else begin
      r_ready_rd <= '0;
      case (r_rstate)
        R_IDLE: begin
          if (w_rany) begin
            r_valid_rd <= 1'b1;
            r_addr_rd  <= w_raddr;
            r_tag_rd   <= w_rtag;
            r_id_rd    <= ID_W'(w_rgidx);
            r_len_rd   <= w_rlen;
            r_qos_rd   <= w_rqos;
            r_ready_rd <= w_rgnt;
            r_rstate   <= R_HOLD;
          end
        end
        R_HOLD: begin
          if (iMAC_ReadyRd) begin
            r_valid_rd <= 1'b0;
            r_rstate   <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Response routing; out-of-range IDs are drained so the MAC never stalls.
  always_comb begin
    w_rsp_rdy = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      oValidRsp[m]  = iMAC_ValidRsp && (iMAC_IdRsp == ID_W'(m));
      w_rsp_rdy     = w_rsp_rdy | ((iMAC_IdRsp == ID_W'(m)) & iReadyRsp[m]);
    end
    w_id_ok = ({1'b0, iMAC_IdRsp} < NUM_M_V);
    if (w_id_ok) begin
      oMAC_ReadyRsp = w_rsp_rdy;
    end else begin
      oMAC_ReadyRsp = 1'b1;
    end
  end

  // Sticky flag for responses carrying an unknown initiator ID.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_id <= 1'b0;
    end else if (iMAC_ValidRsp && !w_id_ok) begin
      r_err_id <= 1'b1;
    end else begin
      r_err_id <= r_err_id;
    end
  end

  assign oReadyWr       = r_ready_wr;
  assign oMAC_ValidWr   = r_valid_wr;
  assign oMAC_AddrWr    = r_addr_wr;
  assign oMAC_TagWr     = r_tag_wr;
  assign oMAC_IdWr      = r_id_wr;
  assign oMAC_LenWr     = r_len_wr;
  assign oMAC_QoSWr     = r_qos_wr;
  assign oMAC_DataValid = w_in_data & w_dv;
  assign oMAC_DataWr    = w_data;
  assign oMAC_MaskWr    = w_mask;
  assign oMAC_EoD       = w_in_data & w_last;
  assign oDataReadyWr   = {NUM_M{w_in_data & iMAC_DataReady}} & w_sel;
  assign oReadyRd       = r_ready_rd;
  assign oMAC_ValidRd   = r_valid_rd;
  assign oMAC_AddrRd    = r_addr_rd;
  assign oMAC_TagRd     = r_tag_rd;
  assign oMAC_IdRd      = r_id_rd;
  assign oMAC_LenRd     = r_len_rd;
  assign oMAC_QoSRd     = r_qos_rd;
  assign oTagRsp        = iMAC_TagRsp;
  assign oDataRsp       = iMAC_DataRsp;
  assign oStatusRsp     = iMAC_StatusRsp;
  assign oEoDRsp        = iMAC_EoD;
  assign oErr           = {r_err_id, r_err_eod};

endmodule
